// File: rtl/wb_stage_pkg.sv
// Shared types and constants for the write-back stage: the control bundle
// coming out of the memory stage, load funct3 encodings, the MEM/WB pipeline
// register layout and small load extension helpers.
package wb_stage_pkg;

    localparam int XLEN      = 32;
    localparam int REG_IDX_W = 5;

    // Control bundle carried down the pipeline from decode.
    typedef struct packed {
        logic       reg_write;
        logic       mem_read;
        logic       mem_to_reg;
        logic [2:0] funct3;
    } control_type;

    // Load funct3 encodings (RV32I).
    localparam logic [2:0] F3_LB  = 3'b000;
    localparam logic [2:0] F3_LH  = 3'b001;
    localparam logic [2:0] F3_LW  = 3'b010;
    localparam logic [2:0] F3_LBU = 3'b100;
    localparam logic [2:0] F3_LHU = 3'b101;

    // MEM/WB pipeline register contents.
    typedef struct packed {
        logic                 valid;
        control_type          ctrl;
        logic [REG_IDX_W-1:0] rd;
        logic [XLEN-1:0]      alu_data;
        logic [XLEN-1:0]      mem_data;
    } mem_wb_type;

    // Widen a byte to XLEN, replicating the top bit when sgn is set.
    function automatic logic [XLEN-1:0] extend_byte(input logic [7:0] b, input logic sgn);
        logic fill;
        fill = sgn & b[7];
        return {{(XLEN-8){fill}}, b};
    endfunction

    // Widen a halfword to XLEN, replicating the top bit when sgn is set.
    function automatic logic [XLEN-1:0] extend_half(input logic [15:0] h, input logic sgn);
        logic fill;
        fill = sgn & h[15];
        return {{(XLEN-16){fill}}, h};
    endfunction

endpackage

// File: rtl/wb_stage_load_formatter.sv
// Combinational load formatter: picks the byte/half addressed by the low
// address bits out of the aligned read word, extends it according to funct3
// and flags misaligned or unsupported load encodings.
module wb_stage_load_formatter
    import wb_stage_pkg::*;
(
    input  logic [XLEN-1:0] mem_data_in,
    input  logic [1:0]      offset_in,
    input  logic [2:0]      funct3_in,
    output logic [XLEN-1:0] data_out,
    output logic            fault_out
);

    logic [7:0]  byte_s;
    logic [15:0] half_s;

    // Select the addressed byte lane of the read word.
    always_comb begin
        byte_s = 8'h00;
        case (offset_in)
            2'd0:    byte_s = mem_data_in[7:0];
            2'd1:    byte_s = mem_data_in[15:8];
            2'd2:    byte_s = mem_data_in[23:16];
            2'd3:    byte_s = mem_data_in[31:24];
            default: byte_s = mem_data_in[7:0];
        endcase
    end

    // Select the addressed halfword; offset bit 0 only matters for the fault check.
    always_comb begin
        half_s = 16'h0000;
        if (offset_in[1]) begin
            half_s = mem_data_in[31:16];
        end else begin
            half_s = mem_data_in[15:0];
        end
    end

    // Extend the selected lane and decide whether the access is legal.
    always_comb begin
        data_out  = {XLEN{1'b0}};
        fault_out = 1'b0;
        case (funct3_in)
            F3_LB: begin
                data_out = extend_byte(byte_s, 1'b1);
            end
            F3_LBU: begin
                data_out = extend_byte(byte_s, 1'b0);
            end
            F3_LH: begin
                data_out  = extend_half(half_s, 1'b1);
                fault_out = offset_in[0];
            end
            F3_LHU: begin
                data_out  = extend_half(half_s, 1'b0);
                fault_out = offset_in[0];
            end
            F3_LW: begin
                data_out  = mem_data_in;
                fault_out = (offset_in != 2'b00);
            end
            default: begin
                // 011, 110, 111 are not loads on RV32I.
                data_out  = {XLEN{1'b0}};
                fault_out = 1'b1;
            end
        endcase
    end

endmodule

// File: rtl/wb_stage.sv
// Write-back stage: MEM/WB pipeline register with stall/flush, load
// formatting, result select, register-file write port (also the forwarding
// source) and the retired-instruction counter. All outputs depend only on
// state, never directly on inputs.
module wb_stage
    import wb_stage_pkg::*;
#(
    parameter int DATA_W    = 32,
    parameter int INSTRET_W = 64
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 stall,
    input  logic                 flush,
    input  logic                 valid_in,
    input  control_type          control_in,
    input  logic [4:0]           rd_in,
    input  logic [DATA_W-1:0]    alu_data_in,
    input  logic [DATA_W-1:0]    memory_data_in,
    output logic                 reg_write_out,
    output logic [4:0]           rd_out,
    output logic [DATA_W-1:0]    wb_data_out,
    output logic                 load_fault_out,
    output logic [INSTRET_W-1:0] instret_out
);

    mem_wb_type           mem_wb_d;
    mem_wb_type           mem_wb_q;
    logic [INSTRET_W-1:0] instret_d;
    logic [INSTRET_W-1:0] instret_q;

    logic [XLEN-1:0] load_data_s;
    logic            fmt_fault_s;
    logic            load_fault_s;
    logic            retire_s;

    wb_stage_load_formatter u_load_formatter (
        .mem_data_in (mem_wb_q.mem_data),
        .offset_in   (mem_wb_q.alu_data[1:0]),
        .funct3_in   (mem_wb_q.ctrl.funct3),
        .data_out    (load_data_s),
        .fault_out   (fmt_fault_s)
    );

    // A formatter fault only matters for a real load sitting in WB.
    always_comb begin
        load_fault_s = mem_wb_q.valid & mem_wb_q.ctrl.mem_read & fmt_fault_s;
    end

    // Next MEM/WB contents: flush inserts a bubble, stall holds, otherwise capture.
    always_comb begin
        mem_wb_d = mem_wb_q;
        if (flush) begin
            mem_wb_d = '0;
        end else if (stall) begin
            mem_wb_d = mem_wb_q;
        end else begin
            mem_wb_d.valid    = valid_in;
            mem_wb_d.ctrl     = control_in;
            mem_wb_d.rd       = rd_in;
            mem_wb_d.alu_data = alu_data_in;
            mem_wb_d.mem_data = memory_data_in;
        end
    end

    // The WB instruction retires when it leaves the stage, either replaced
    // or overwritten by a flush; a faulting load never counts.
    always_comb begin
        retire_s  = mem_wb_q.valid & ~load_fault_s & (~stall | flush);
        instret_d = instret_q + {{(INSTRET_W-1){1'b0}}, retire_s};
    end

    // Pipeline register and counter, with synchronous reset dominating everything.
    always_ff @(posedge clk) begin
        if (reset) begin
            mem_wb_q  <= '0;
            instret_q <= {INSTRET_W{1'b0}};
        end else begin
            mem_wb_q  <= mem_wb_d;
            instret_q <= instret_d;
        end
    end

    // Register-file write port and status, driven from state only.
    always_comb begin
        reg_write_out  = mem_wb_q.valid & mem_wb_q.ctrl.reg_write
                       & (mem_wb_q.rd != 5'd0) & ~load_fault_s;
        rd_out         = mem_wb_q.rd;
        load_fault_out = load_fault_s;
        instret_out    = instret_q;
        if (mem_wb_q.ctrl.mem_to_reg) begin
            wb_data_out = load_data_s;
        end else begin
            wb_data_out = mem_wb_q.alu_data;
        end
    end

endmodule

// File: tb/tb_wb_stage.sv
// Self-checking bench for wb_stage: table-driven load/ALU vectors, hand
// sequences for stall, flush, reset and counter wrap, then randomized traffic
// compared against an arithmetic reference model.
module tb_wb_stage;
    import wb_stage_pkg::*;

    logic        clk;
    logic        reset, stall, flush, valid_in;
    control_type control_in;
    logic [4:0]  rd_in;
    logic [31:0] alu_data_in, memory_data_in;

    logic        reg_write_out, load_fault_out;
    logic [4:0]  rd_out;
    logic [31:0] wb_data_out;
    logic [63:0] instret_out;

    logic        s_reg_write, s_fault;
    logic [4:0]  s_rd;
    logic [31:0] s_data;
    logic [2:0]  s_instret;

    wb_stage dut (
        .clk(clk), .reset(reset), .stall(stall), .flush(flush),
        .valid_in(valid_in), .control_in(control_in), .rd_in(rd_in),
        .alu_data_in(alu_data_in), .memory_data_in(memory_data_in),
        .reg_write_out(reg_write_out), .rd_out(rd_out), .wb_data_out(wb_data_out),
        .load_fault_out(load_fault_out), .instret_out(instret_out)
    );

    // Narrow-counter copy, used to exercise wrap-around in a few retirements.
    wb_stage #(.INSTRET_W(3)) dut_small (
        .clk(clk), .reset(reset), .stall(stall), .flush(flush),
        .valid_in(valid_in), .control_in(control_in), .rd_in(rd_in),
        .alu_data_in(alu_data_in), .memory_data_in(memory_data_in),
        .reg_write_out(s_reg_write), .rd_out(s_rd), .wb_data_out(s_data),
        .load_fault_out(s_fault), .instret_out(s_instret)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Reference model state: the instruction currently in WB and the count.
    logic        m_valid, m_rw, m_mr, m_m2r, m_dc;
    logic [2:0]  m_f3;
    logic [4:0]  m_rd;
    logic [31:0] m_alu, m_mem;
    logic [63:0] m_cnt;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    // Load result computed from the ISA rules with plain shifts and arithmetic.
    function automatic logic [31:0] ref_load(input logic [2:0] f3, input logic [31:0] w,
                                             input logic [1:0] off, output logic bad);
        int unsigned b, h;
        logic [31:0] r;
        b   = (w >> (8 * off)) & 32'hFF;
        h   = (w >> (16 * off[1])) & 32'hFFFF;
        bad = 1'b0;
        r   = 32'd0;
        case (f3)
            3'b000:  r = b - ((b >= 128) ? 32'd256 : 32'd0);
            3'b100:  r = b;
            3'b001:  begin r = h - ((h >= 32768) ? 32'd65536 : 32'd0); bad = off[0]; end
            3'b101:  begin r = h; bad = off[0]; end
            3'b010:  begin r = w; bad = (off != 2'd0); end
            default: bad = 1'b1;
        endcase
        return r;
    endfunction

    function automatic logic model_fault();
        logic bad;
        logic [31:0] unused_d;
        unused_d = ref_load(m_f3, m_mem, m_alu[1:0], bad);
        return m_valid & m_mr & bad;
    endfunction

    // Drive one cycle of inputs, advance the model across the edge, settle.
    task automatic step(input logic st, input logic fl, input logic rs, input logic v,
                        input control_type c, input logic [4:0] rd,
                        input logic [31:0] alu, input logic [31:0] mem);
        logic ret;
        reset = rs; stall = st; flush = fl; valid_in = v;
        control_in = c; rd_in = rd; alu_data_in = alu; memory_data_in = mem;
        ret = m_valid & ~model_fault() & (~st | fl);
        @(posedge clk);
        if (rs) begin
            {m_valid, m_rw, m_mr, m_m2r, m_dc, m_f3, m_rd, m_alu, m_mem} = '0;
            m_cnt = 64'd0;
        end else begin
            if (ret) m_cnt = m_cnt + 64'd1;
            if (fl) begin
                m_valid = 1'b0; m_dc = 1'b1;
            end else if (!st) begin
                m_valid = v; m_rw = c.reg_write; m_mr = c.mem_read; m_m2r = c.mem_to_reg;
                m_f3 = c.funct3; m_rd = rd; m_alu = alu; m_mem = mem; m_dc = 1'b0;
            end
        end
        #1;
    endtask

    // Compare every output with what the model predicts.
    task automatic check_all(input string tag);
        logic bad, f, we;
        logic [31:0] fd;
        fd = ref_load(m_f3, m_mem, m_alu[1:0], bad);
        f  = m_valid & m_mr & bad;
        we = m_valid & m_rw & (m_rd != 5'd0) & ~f;
        chk({tag, "/we"}, reg_write_out, we);
        chk({tag, "/fault"}, load_fault_out, f);
        if (!m_dc) begin
            chk({tag, "/rd"}, rd_out, m_rd);
            if (!f) chk({tag, "/data"}, wb_data_out, m_m2r ? fd : m_alu);
        end
        chk({tag, "/instret"}, instret_out, m_cnt);
        chk({tag, "/instret3"}, s_instret, {61'd0, m_cnt[2:0]});
    endtask

    typedef struct {
        logic [2:0]  f3;
        logic        m2r;
        logic        mr;
        logic [4:0]  rd;
        logic [31:0] alu;
        logic [31:0] mem;
        logic [31:0] exp_data;
        logic        exp_we;
        logic        exp_fault;
        logic        chk_data;
    } vec_t;

    vec_t        vq[$];
    control_type cz, cv;
    logic [63:0] base;

    initial begin
        cz = '{reg_write: 1'b0, mem_read: 1'b0, mem_to_reg: 1'b0, funct3: 3'b000};
        reset = 1'b1; stall = 1'b0; flush = 1'b0; valid_in = 1'b0;
        control_in = cz; rd_in = 5'd0; alu_data_in = 32'd0; memory_data_in = 32'd0;
        {m_valid, m_rw, m_mr, m_m2r, m_dc, m_f3, m_rd, m_alu, m_mem} = '0;
        m_cnt = 64'd0;

        // Reset state.
        step(1'b0, 1'b0, 1'b1, 1'b1, cz, 5'd9, 32'h5555_AAAA, 32'h1);
        step(1'b0, 1'b0, 1'b1, 1'b1, cz, 5'd9, 32'h5555_AAAA, 32'h1);
        chk("rst/we", reg_write_out, 1'b0);
        chk("rst/rd", rd_out, 5'd0);
        chk("rst/data", wb_data_out, 32'd0);
        chk("rst/fault", load_fault_out, 1'b0);
        chk("rst/instret", instret_out, 64'd0);

        // Directed load / ALU vectors.
        vq.push_back('{3'b000, 1'b1, 1'b1, 5'd3, 32'h1000, 32'h80FF7F01, 32'h00000001, 1'b1, 1'b0, 1'b1});
        vq.push_back('{3'b000, 1'b1, 1'b1, 5'd3, 32'h1001, 32'h80FF7F01, 32'h0000007F, 1'b1, 1'b0, 1'b1});
        vq.push_back('{3'b000, 1'b1, 1'b1, 5'd3, 32'h1002, 32'h80FF7F01, 32'hFFFFFFFF, 1'b1, 1'b0, 1'b1});
        vq.push_back('{3'b000, 1'b1, 1'b1, 5'd3, 32'h1003, 32'h80FF7F01, 32'hFFFFFF80, 1'b1, 1'b0, 1'b1});
        vq.push_back('{3'b100, 1'b1, 1'b1, 5'd4, 32'h1000, 32'h80FF7F01, 32'h00000001, 1'b1, 1'b0, 1'b1});
        vq.push_back('{3'b100, 1'b1, 1'b1, 5'd4, 32'h1001, 32'h80FF7F01, 32'h0000007F, 1'b1, 1'b0, 1'b1});
        vq.push_back('{3'b100, 1'b1, 1'b1, 5'd4, 32'h1002, 32'h80FF7F01, 32'h000000FF, 1'b1, 1'b0, 1'b1});
        vq.push_back('{3'b100, 1'b1, 1'b1, 5'd4, 32'h1003, 32'h80FF7F01, 32'h00000080, 1'b1, 1'b0, 1'b1});
        vq.push_back('{3'b001, 1'b1, 1'b1, 5'd6, 32'h2002, 32'h80011234, 32'hFFFF8001, 1'b1, 1'b0, 1'b1});
        vq.push_back('{3'b101, 1'b1, 1'b1, 5'd6, 32'h2002, 32'h80011234, 32'h00008001, 1'b1, 1'b0, 1'b1});
        vq.push_back('{3'b001, 1'b1, 1'b1, 5'd6, 32'h2000, 32'h80011234, 32'h00001234, 1'b1, 1'b0, 1'b1});
        vq.push_back('{3'b001, 1'b1, 1'b1, 5'd6, 32'h2001, 32'h80011234, 32'h0, 1'b0, 1'b1, 1'b0});
        vq.push_back('{3'b010, 1'b1, 1'b1, 5'd7, 32'h3000, 32'h80011234, 32'h80011234, 1'b1, 1'b0, 1'b1});
        vq.push_back('{3'b010, 1'b1, 1'b1, 5'd7, 32'h3002, 32'h80011234, 32'h0, 1'b0, 1'b1, 1'b0});
        vq.push_back('{3'b011, 1'b1, 1'b1, 5'd7, 32'h3000, 32'h80011234, 32'h0, 1'b0, 1'b1, 1'b0});
        vq.push_back('{3'b110, 1'b1, 1'b1, 5'd7, 32'h3000, 32'h80011234, 32'h0, 1'b0, 1'b1, 1'b0});
        vq.push_back('{3'b000, 1'b0, 1'b0, 5'd5, 32'hDEADBEEF, 32'h12345678, 32'hDEADBEEF, 1'b1, 1'b0, 1'b1});
        vq.push_back('{3'b000, 1'b0, 1'b0, 5'd0, 32'hDEADBEEF, 32'h12345678, 32'hDEADBEEF, 1'b0, 1'b0, 1'b1});
        foreach (vq[i]) begin
            cv = '{reg_write: 1'b1, mem_read: vq[i].mr, mem_to_reg: vq[i].m2r, funct3: vq[i].f3};
            base = m_cnt;
            step(1'b0, 1'b0, 1'b0, 1'b1, cv, vq[i].rd, vq[i].alu, vq[i].mem);
            chk($sformatf("vec%0d/we", i), reg_write_out, vq[i].exp_we);
            chk($sformatf("vec%0d/fault", i), load_fault_out, vq[i].exp_fault);
            if (vq[i].chk_data) chk($sformatf("vec%0d/data", i), wb_data_out, vq[i].exp_data);
            if (i > 0 && vq[i-1].exp_fault) chk($sformatf("vec%0d/nocount", i), instret_out, base);
            check_all($sformatf("vec%0d", i));
        end
        // rd=0 ALU op in WB retires when replaced.
        base = m_cnt;
        step(1'b0, 1'b0, 1'b0, 1'b0, cz, 5'd0, 32'd0, 32'd0);
        chk("rd0/counted", instret_out, base + 64'd1);

        // Stall three cycles with a valid ALU op held in WB.
        cv = '{reg_write: 1'b1, mem_read: 1'b0, mem_to_reg: 1'b0, funct3: 3'b000};
        step(1'b0, 1'b0, 1'b0, 1'b1, cv, 5'd5, 32'hDEADBEEF, 32'h0);
        base = m_cnt;
        for (int k = 0; k < 3; k++) begin
            step(1'b1, 1'b0, 1'b0, 1'b1, cv, 5'd9, $urandom, $urandom);
            chk($sformatf("stall%0d/we", k), reg_write_out, 1'b1);
            chk($sformatf("stall%0d/data", k), wb_data_out, 32'hDEADBEEF);
            chk($sformatf("stall%0d/rd", k), rd_out, 5'd5);
            chk($sformatf("stall%0d/instret", k), instret_out, base);
        end
        step(1'b0, 1'b0, 1'b0, 1'b0, cz, 5'd0, 32'd0, 32'd0);
        chk("unstall/instret", instret_out, base + 64'd1);
        chk("unstall/we", reg_write_out, 1'b0);

        // Stall and flush together: bubble in, held instruction counted.
        step(1'b0, 1'b0, 1'b0, 1'b1, cv, 5'd7, 32'h1234, 32'h0);
        base = m_cnt;
        step(1'b1, 1'b1, 1'b0, 1'b1, cv, 5'd8, 32'h5678, 32'h0);
        chk("stflush/we", reg_write_out, 1'b0);
        chk("stflush/fault", load_fault_out, 1'b0);
        chk("stflush/instret", instret_out, base + 64'd1);
        check_all("stflush");

        // Reach a count of 7, then reset during a stall.
        step(1'b0, 1'b0, 1'b1, 1'b0, cz, 5'd0, 32'd0, 32'd0);
        for (int k = 0; k < 8; k++) step(1'b0, 1'b0, 1'b0, 1'b1, cv, 5'd1, k, 32'd0);
        chk("pre_rst/instret", instret_out, 64'd7);
        chk("pre_rst/instret3", s_instret, 3'd7);
        step(1'b1, 1'b0, 1'b0, 1'b1, cv, 5'd2, 32'h99, 32'd0);
        step(1'b1, 1'b0, 1'b1, 1'b1, cv, 5'd2, 32'h99, 32'd0);
        chk("midrst/we", reg_write_out, 1'b0);
        chk("midrst/rd", rd_out, 5'd0);
        chk("midrst/data", wb_data_out, 32'd0);
        chk("midrst/instret", instret_out, 64'd0);

        // Eight retirements wrap the 3-bit counter back to zero.
        for (int k = 0; k < 9; k++) step(1'b0, 1'b0, 1'b0, 1'b1, cv, 5'd3, k, 32'd0);
        chk("wrap/instret3", s_instret, 3'd0);
        chk("wrap/instret", instret_out, 64'd8);

        // Randomized traffic against the model.
        for (int n = 0; n < 600; n++) begin
            logic [4:0] rr;
            cv.reg_write  = $urandom_range(0, 3) != 0;
            cv.mem_read   = $urandom_range(0, 1);
            cv.mem_to_reg = cv.mem_read ? ($urandom_range(0, 7) != 0) : ($urandom_range(0, 7) == 0);
            cv.funct3     = 3'($urandom);
            rr = ($urandom_range(0, 7) == 0) ? 5'd0 : 5'($urandom);
            step($urandom_range(0, 3) == 0, $urandom_range(0, 9) == 0, $urandom_range(0, 59) == 0,
                 $urandom_range(0, 4) != 0, cv, rr, $urandom, $urandom);
            check_all($sformatf("rnd%0d", n));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
